instr_fetch: RTL
================

# instr_fetch

Fetch stage of the ARM7 core. It owns the program counter and drives `PC`/`read_enable` into the instruction cache. It captures each returned instruction, tagged with its address, into a 2-entry prefetch buffer, and hands instructions to decode through a valid/ready handshake. Branch redirects from execute flush the buffer and reload the PC.

## Interface
- `N`, 32: PC / address width.
- `instr_size`, 32: instruction width.
- `RESET_VECTOR`, 32'h0000_0000: PC value after reset; bits [1:0] must be 0.
- `clk`  input  1  core clock. All state updates on posedge. The cache samples `PC` on negedge.
- `rst_n`  input  1  asynchronous, active-low reset.
- `PC`  output  N  fetch address to the instruction cache. The cache uses bits [addr_size+1:2].
- `read_enable`  output  1  fetch request to the cache for the current `PC`.
- `instr`  input  instr_size  cache read data, valid after the negedge of a cycle in which `read_enable`=1.
- `branch_valid`  input  1  redirect request from execute.
- `branch_target`  input  N  redirect address. Bits [1:0] are ignored and forced to 0.
- `dec_valid`  output  1  head of the prefetch buffer is valid.
- `dec_ready`  input  1  decode accepts the head this cycle.
- `dec_instr`  output  instr_size  head instruction.
- `dec_pc`  output  N  address of the head instruction.
- `dec_pc_plus8`  output  N  `dec_pc + 8` modulo 2^N, the architectural r15 read value.

## Operation
- State: `pc_q` (drives `PC`), 2-entry FIFO of {instr, pc}, `count` (0..2), write pointer, read pointer.
- pop = `dec_valid & dec_ready`.
- space = (count < 2) | pop.
- `read_enable` = space & ~`branch_valid`. This is combinational.
- Fetch cycle: when `read_enable`=1 at posedge k, the cache returns M[pc_q] at the negedge within cycle k. At posedge k+1 the block does the following:
  - pushes {`instr`, pc_q} into the FIFO;
  - updates pc_q <= pc_q + 4, wrapping modulo 2^N (32'hFFFF_FFFC -> 32'h0).
- No fetch (`read_enable`=0, not branching): pc_q holds and nothing is pushed.
- Push and pop in the same cycle: count is unchanged. This is legal at count=1 and at count=2.
- `dec_valid` = (count != 0) & ~`branch_valid`. `dec_instr`/`dec_pc` come from the FIFO head. When count=0 they show the last head, and their value is don't-care.
- Branch (`branch_valid`=1 at a posedge):
  - count <= 0 and both pointers <= 0;
  - pc_q <= {`branch_target`[N-1:2], 2'b00};
  - no push, and no pop is counted even if `dec_ready`=1.
  - Fetching resumes on the following cycle at the target.
- The FIFO never overflows: a push only happens when space=1. A pop never occurs when count=0.

## Timing
- Reset (async assert, sync-to-clk release assumed at top level): pc_q = RESET_VECTOR, count = 0, pointers = 0, `read_enable` = 1 (space=1), `dec_valid` = 0, `dec_instr` = 0, `dec_pc` = 0, `dec_pc_plus8` = 8, FIFO storage = 0.
- Reset asserted mid-fetch: the in-flight fetch is discarded. The first post-reset fetch is at RESET_VECTOR.
- Latency from reset release to first `dec_valid`: 1 cycle (fetch in cycle 0, valid after posedge 1).
- Latency from branch to first target instruction on `dec_valid`: 2 cycles (flush edge, then fetch edge).
- Throughput: 1 instruction/cycle while `dec_ready`=1.
- `dec_ready` low: the buffer fills to 2 and then `read_enable` drops. pc_q equals the address after the last buffered entry.
- `read_enable`, `dec_valid` and space are combinational from `dec_ready`/`branch_valid`/count. There are no combinational paths from `instr`.

## Test plan
- Reset, then `dec_ready`=1 and cache holds M[i]=32'hE3A0_7000+i:
  - `dec_valid` rises after 1 cycle;
  - `dec_pc` runs 0,4,8,... on consecutive cycles with `dec_instr`=M[0],M[1],...;
  - `dec_pc_plus8`=`dec_pc`+8.
- Backpressure: `dec_ready`=0 for 5 cycles starting when head pc=8.
  - count saturates at 2 (pcs 8,12);
  - `read_enable`=0 and PC=16 hold;
  - after release, pcs 8,12,16,20 follow with no gap and no duplicate.
- Branch with full buffer: `branch_valid`=1, target 32'h0000_0043.
  - `dec_valid`=0 that cycle;
  - next cycle PC=32'h40 and `read_enable`=1;
  - following cycle `dec_pc`=32'h40 and none of the old entries appear.
- Branch while `dec_ready`=1 and count=1: the head is not counted as consumed, and the next delivered `dec_pc` is the target.
- Wrap: force PC region near 32'hFFFF_FFF8 via branch. Delivered pcs are FFFF_FFF8, FFFF_FFFC, 0000_0000, with `dec_pc_plus8` for FFFF_FFFC equal to 32'h4.
- Async reset asserted mid-stream with count=2 and `dec_ready`=0:
  - all outputs go to reset values immediately, without waiting for a clock;
  - after release, the first delivered `dec_pc` is RESET_VECTOR.

Source files
------------

// File: rtl/instr_fetch.sv
`default_nettype none
// ============================================================================
// Module      : instr_fetch
// Description : ARM7 fetch stage - PC generation, 2-entry prefetch buffer,
//               valid/ready hand-off to decode, branch flush/redirect.
// Revision    : 1.0 - initial release
// ============================================================================
module instr_fetch #(
    parameter int            N            = 32,
    parameter int            INSTR_SIZE   = 32,
    parameter logic [N-1:0]  RESET_VECTOR = '0
) (
    input  logic                  clk,
    input  logic                  rst_n,
    output logic [N-1:0]          PC,
    output logic                  read_enable,
    input  logic [INSTR_SIZE-1:0] instr,
    input  logic                  branch_valid,
    input  logic [N-1:0]          branch_target,
    output logic                  dec_valid,
    input  logic                  dec_ready,
    output logic [INSTR_SIZE-1:0] dec_instr,
    output logic [N-1:0]          dec_pc,
    output logic [N-1:0]          dec_pc_plus8
);

    localparam logic [1:0]   c_DEPTH   = 2'd2;
    localparam logic [N-1:0] c_PC_STEP = N'(4);
    localparam logic [N-1:0] c_PC_R15  = N'(8);

    logic [N-1:0]          r_pc;
    logic [INSTR_SIZE-1:0] r_buf_instr [2];
    logic [N-1:0]          r_buf_pc    [2];
    logic [1:0]            r_count;
    logic                  r_wr_ptr;
    logic                  r_rd_ptr;

    logic w_pop;
    logic w_space;
    logic w_push;
    logic w_unused_target_lsbs;

    assign w_unused_target_lsbs = &{1'b0, branch_target[1:0]};

    // Nothing handshake- or fetch-related may depend on instr: it arrives late in the cycle.
    assign dec_valid   = (r_count != 2'd0) & ~branch_valid;
    assign w_pop       = dec_valid & dec_ready;
    assign w_space     = (r_count < c_DEPTH) | w_pop;
    assign read_enable = w_space & ~branch_valid;
    assign w_push      = read_enable;

    assign PC           = r_pc;
    assign dec_instr    = r_buf_instr[r_rd_ptr];
    assign dec_pc       = r_buf_pc[r_rd_ptr];
    assign dec_pc_plus8 = r_buf_pc[r_rd_ptr] + c_PC_R15;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pc           <= RESET_VECTOR;
            r_count        <= 2'd0;
            r_wr_ptr       <= 1'b0;
            r_rd_ptr       <= 1'b0;
            r_buf_instr[0] <= '0;
            r_buf_instr[1] <= '0;
            r_buf_pc[0]    <= '0;
            r_buf_pc[1]    <= '0;
        end else if (branch_valid) begin
            // Redirect squashes everything buffered; a concurrent dec_ready is not a consume.
            r_pc     <= {branch_target[N-1:2], 2'b00};
            r_count  <= 2'd0;
            r_wr_ptr <= 1'b0;
            r_rd_ptr <= 1'b0;
        end else begin
            if (w_push) begin
                r_buf_instr[r_wr_ptr] <= instr;
                r_buf_pc[r_wr_ptr]    <= r_pc;
                r_wr_ptr              <= ~r_wr_ptr;
                r_pc                  <= r_pc + c_PC_STEP;
            end
            if (w_pop) begin
                r_rd_ptr <= ~r_rd_ptr;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 2'd1;
                2'b01:   r_count <= r_count - 2'd1;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule
`default_nettype wire
